// File: rtl/xmul_pkg.sv
// Shared definitions for the extended-multiplier issue controller: function
// codes, default widths and the legal-function decoder.
package xmul_pkg;

    localparam int XLEN_DEF = 64;
    localparam int TAGW_DEF = 5;
    localparam int FN_W     = 6;

    localparam logic [FN_W-1:0] FN_MUL    = 6'd0;
    localparam logic [FN_W-1:0] FN_MULH   = 6'd1;
    localparam logic [FN_W-1:0] FN_MULHSU = 6'd2;
    localparam logic [FN_W-1:0] FN_MULHU  = 6'd3;
    localparam logic [FN_W-1:0] FN_MADDL  = 6'd52;
    localparam logic [FN_W-1:0] FN_MADDH  = 6'd53;

    function automatic logic is_legal_fn(input logic [FN_W-1:0] fn);
        case (fn)
            FN_MUL, FN_MULH, FN_MULHSU, FN_MULHU, FN_MADDL, FN_MADDH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/xmul_resp_fifo.sv
// Synchronous response FIFO with first-word-fall-through head and occupancy count.
module xmul_resp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop  = i_pop & (r_count != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_do_push = i_push & ((r_count != CW'(DEPTH)) | w_do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/xmul_issue_ctrl.sv
// Issue controller for the fixed-latency extended multiplier: rebuilds response
// timing with a two-stage delay line and buffers results under credit control.
module xmul_issue_ctrl
    import xmul_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEF,
    parameter int TAGW  = TAGW_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [5:0]      cmd_fn,
    input  logic            cmd_dw,
    input  logic [TAGW-1:0] cmd_tag,
    input  logic [XLEN-1:0] cmd_in1,
    input  logic [XLEN-1:0] cmd_in2,
    input  logic [XLEN-1:0] cmd_in3,
    output logic            mul_req_valid,
    output logic            mul_req_bits_dw,
    output logic [5:0]      mul_req_bits_fn,
    output logic [TAGW-1:0] mul_req_bits_tag,
    output logic [XLEN-1:0] mul_req_bits_in1,
    output logic [XLEN-1:0] mul_req_bits_in2,
    output logic [XLEN-1:0] mul_req_in3,
    input  logic [XLEN-1:0] mul_resp_data,
    input  logic [TAGW-1:0] mul_resp_tag,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [TAGW-1:0] wb_tag,
    output logic            wb_err,
    output logic            busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;
    localparam int FW = 1 + TAGW + XLEN;

    logic            w_fire;
    logic            w_legal;
    logic            r_s0_v;
    logic            r_s0_err;
    logic [TAGW-1:0] r_s0_tag;
    logic            r_s1_v;
    logic            r_s1_err;
    logic [TAGW-1:0] r_s1_tag;
    logic [1:0]      w_inflight;
    logic [CW-1:0]   w_count;
    logic [OW-1:0]   w_occupancy;
    logic [FW-1:0]   w_push_entry;
    logic [FW-1:0]   w_head;
    logic            w_wb_valid;
    logic            w_pop;

    assign w_legal = is_legal_fn(cmd_fn);
    assign w_fire  = cmd_valid & cmd_ready;

    assign mul_req_valid    = w_fire & w_legal;
    assign mul_req_bits_dw  = cmd_dw;
    assign mul_req_bits_fn  = cmd_fn;
    assign mul_req_bits_tag = cmd_tag;
    assign mul_req_bits_in1 = cmd_in1;
    assign mul_req_bits_in2 = cmd_in2;
    assign mul_req_in3      = cmd_in3;

    // Mirrors the multiplier pipeline so we know when its output is meaningful.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s0_v   <= 1'b0;
            r_s0_err <= 1'b0;
            r_s0_tag <= '0;
            r_s1_v   <= 1'b0;
            r_s1_err <= 1'b0;
            r_s1_tag <= '0;
        end else begin
            r_s0_v   <= w_fire;
            r_s0_err <= ~w_legal;
            r_s0_tag <= cmd_tag;
            r_s1_v   <= r_s0_v;
            r_s1_err <= r_s0_err;
            r_s1_tag <= r_s0_tag;
        end
    end

    // Credits count in-flight ops as already occupying the FIFO; pops this cycle are ignored.
    assign w_inflight  = {1'b0, r_s0_v} + {1'b0, r_s1_v};
    assign w_occupancy = {1'b0, w_count} + OW'(w_inflight);
    assign cmd_ready   = ~reset & (w_occupancy < OW'(DEPTH));

    assign w_push_entry = r_s1_err ? {1'b1, r_s1_tag, {XLEN{1'b0}}}
                                   : {1'b0, mul_resp_tag, mul_resp_data};

    xmul_resp_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_resp_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (r_s1_v),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    assign w_wb_valid = ~reset & (w_count != '0);
    assign w_pop      = w_wb_valid & wb_ready;

    // Head fields are masked so stale RAM contents never reach the core.
    assign wb_valid = w_wb_valid;
    assign wb_data  = w_wb_valid ? w_head[XLEN-1:0]         : '0;
    assign wb_tag   = w_wb_valid ? w_head[XLEN +: TAGW]     : '0;
    assign wb_err   = w_wb_valid ? w_head[FW-1]             : 1'b0;
    assign busy     = ~reset & ((w_inflight != 2'd0) | (w_count != '0));

endmodule

// File: tb/tb_xmul_issue_ctrl.sv
// Scoreboard bench for xmul_issue_ctrl with a 2-cycle multiplier stand-in.
module tb_xmul_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int TAGW  = 5;

    logic            clock;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [5:0]      cmd_fn;
    logic            cmd_dw;
    logic [TAGW-1:0] cmd_tag;
    logic [XLEN-1:0] cmd_in1;
    logic [XLEN-1:0] cmd_in2;
    logic [XLEN-1:0] cmd_in3;
    logic            mul_req_valid;
    logic            mul_req_bits_dw;
    logic [5:0]      mul_req_bits_fn;
    logic [TAGW-1:0] mul_req_bits_tag;
    logic [XLEN-1:0] mul_req_bits_in1;
    logic [XLEN-1:0] mul_req_bits_in2;
    logic [XLEN-1:0] mul_req_in3;
    logic [XLEN-1:0] mul_resp_data;
    logic [TAGW-1:0] mul_resp_tag;
    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_data;
    logic [TAGW-1:0] wb_tag;
    logic            wb_err;
    logic            busy;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] data;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    xmul_issue_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN), .TAGW(TAGW)) dut (
        .clock            (clock),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_fn           (cmd_fn),
        .cmd_dw           (cmd_dw),
        .cmd_tag          (cmd_tag),
        .cmd_in1          (cmd_in1),
        .cmd_in2          (cmd_in2),
        .cmd_in3          (cmd_in3),
        .mul_req_valid    (mul_req_valid),
        .mul_req_bits_dw  (mul_req_bits_dw),
        .mul_req_bits_fn  (mul_req_bits_fn),
        .mul_req_bits_tag (mul_req_bits_tag),
        .mul_req_bits_in1 (mul_req_bits_in1),
        .mul_req_bits_in2 (mul_req_bits_in2),
        .mul_req_in3      (mul_req_in3),
        .mul_resp_data    (mul_resp_data),
        .mul_resp_tag     (mul_resp_tag),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_data          (wb_data),
        .wb_tag           (wb_tag),
        .wb_err           (wb_err),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Multiplier stand-in: two register stages, no valid, reset with the controller.
    function automatic logic [63:0] mul_model(input logic [5:0] fn, input logic dw,
                                              input logic [63:0] a, input logic [63:0] b,
                                              input logic [63:0] c);
        logic [127:0] p;
        logic [113:0] p57;
        p57 = {57'd0, a[56:0]} * {57'd0, b[56:0]};
        case (fn)
            6'd0: begin
                p = {64'd0, a} * {64'd0, b};
                return dw ? p[63:0] : {{32{p[31]}}, p[31:0]};
            end
            6'd1: begin
                p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
                return p[127:64];
            end
            6'd2: begin
                p = {{64{a[63]}}, a} * {64'd0, b};
                return p[127:64];
            end
            6'd3: begin
                p = {64'd0, a} * {64'd0, b};
                return p[127:64];
            end
            6'd52: return {7'd0, p57[56:0]} + c;
            6'd53: return {7'd0, p57[113:57]} + c;
            default: return 64'd0;
        endcase
    endfunction

    logic [63:0]     m_d1, m_d2;
    logic [TAGW-1:0] m_t1, m_t2;
    always @(posedge clock) begin
        if (reset) begin
            m_d1 <= '0; m_d2 <= '0; m_t1 <= '0; m_t2 <= '0;
        end else begin
            m_d1 <= mul_model(mul_req_bits_fn, mul_req_bits_dw, mul_req_bits_in1,
                              mul_req_bits_in2, mul_req_in3);
            m_t1 <= mul_req_bits_tag;
            m_d2 <= m_d1;
            m_t2 <= m_t1;
        end
    end
    assign mul_resp_data = m_d2;
    assign mul_resp_tag  = m_t2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every writeback handshake is matched against the queue head.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_wb: got tag %0d data 0x%0h, expected no entry", wb_tag, wb_data);
            end else begin
                e = exp_q.pop_front();
                $display("wb tag=%0d data=0x%0h err=%0d", wb_tag, wb_data, wb_err);
                check("wb_tag", 64'(wb_tag), 64'(e.tag));
                check("wb_data", wb_data, e.data);
                check("wb_err", 64'(wb_err), 64'(e.err));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Offers one command (called at posedge+1), waits for acceptance, queues the expected result.
    task automatic send(input logic [5:0] fn, input logic dw, input logic [TAGW-1:0] tag,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic [63:0] exp_d, input logic exp_err);
        int waited;
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_fn    = fn;
        cmd_dw    = dw;
        cmd_tag   = tag;
        cmd_in1   = a;
        cmd_in2   = b;
        cmd_in3   = c;
        #1;
        while (!cmd_ready && waited < 100) begin
            tick(1);
            waited++;
        end
        if (!cmd_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: tag %0d not accepted, expected acceptance within 100 cycles", tag);
            cmd_valid = 1'b0;
            return;
        end
        $display("cmd fn=%0d tag=%0d accepted", fn, tag);
        check("mul_req_valid", 64'(mul_req_valid), 64'(!exp_err));
        exp_q.push_back('{tag: tag, data: exp_d, err: exp_err});
        tick(1);
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy) && w < 200) begin
            tick(1);
            w++;
        end
        check("drain_done", 64'(exp_q.size() == 0 && !busy), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b1; cmd_fn = 6'd0; cmd_dw = 1'b1; cmd_tag = '0;
        cmd_in1 = '0; cmd_in2 = '0; cmd_in3 = '0; wb_ready = 1'b1;

        // Reset values, with a legal command offered during reset.
        tick(3);
        @(negedge clock);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mul_req_valid", 64'(mul_req_valid), 64'd0);
        cmd_valid = 1'b0;
        tick(1);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("post_rst_wb_valid", 64'(wb_valid), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_wb_data", wb_data, 64'd0);
        tick(1);

        // Single MUL and its latency: FIFO written two edges after accept.
        send(6'd0, 1'b1, 5'd7, 64'd3, 64'd5, 64'd0, 64'd15, 1'b0);
        idle();
        @(negedge clock);
        @(negedge clock);
        check("lat_wb_valid_early", 64'(wb_valid), 64'd0);
        @(negedge clock);
        check("lat_wb_valid_on_time", 64'(wb_valid), 64'd1);
        tick(1);
        drain();

        // MADD57 low/high.
        send(6'd52, 1'b1, 5'd3, 64'h0100_0000_0000_0000, 64'd4, 64'd7, 64'd7, 1'b0);
        send(6'd53, 1'b1, 5'd4, 64'h0100_0000_0000_0000, 64'd4, 64'd0, 64'd2, 1'b0);
        idle();
        drain();

        // Back-to-back: results must stream out on consecutive cycles.
        send(6'd1, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b0);
        send(6'd3, 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd1, 1'b0);
        send(6'd0, 1'b0, 5'd8, 64'h0000_0000_8000_0000, 64'd1, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("stream_wb_valid", 64'(wb_valid), (i < 3) ? 64'd1 : 64'd0);
        end
        tick(1);
        drain();

        // Fill with writeback stalled: credits close after the 4th accept.
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(6'd0, 1'b1, 5'(10 + i), 64'(10 + i), 64'd2, 64'd0, 64'(2 * (10 + i)), 1'b0);
        check("full_cmd_ready", 64'(cmd_ready), 64'd0);
        tick(4);
        check("full_cmd_ready_hold", 64'(cmd_ready), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        check("full_head_tag", 64'(wb_tag), 64'd10);
        fork
            begin
                send(6'd0, 1'b1, 5'd14, 64'd14, 64'd2, 64'd0, 64'd28, 1'b0);
                send(6'd0, 1'b1, 5'd15, 64'd15, 64'd2, 64'd0, 64'd30, 1'b0);
                idle();
            end
            begin
                tick(3);
                wb_ready = 1'b1;
            end
        join
        drain();

        // Illegal fn keeps its slot in program order.
        send(6'd0, 1'b1, 5'd1, 64'd6, 64'd7, 64'd0, 64'd42, 1'b0);
        send(6'd10, 1'b1, 5'd2, 64'd6, 64'd7, 64'd0, 64'd0, 1'b1);
        send(6'd0, 1'b1, 5'd3, 64'd9, 64'd9, 64'd0, 64'd81, 1'b0);
        idle();
        drain();

        // Reset with two in flight and one buffered discards everything.
        wb_ready = 1'b0;
        send(6'd0, 1'b1, 5'd20, 64'd1, 64'd1, 64'd0, 64'd1, 1'b0);
        send(6'd0, 1'b1, 5'd21, 64'd2, 64'd1, 64'd0, 64'd2, 1'b0);
        send(6'd0, 1'b1, 5'd22, 64'd3, 64'd1, 64'd0, 64'd3, 1'b0);
        idle();
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        check("mid_rst_wb_valid", 64'(wb_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        tick(2);
        reset = 1'b0;
        @(negedge clock);
        check("after_rst_wb_valid", 64'(wb_valid), 64'd0);
        check("after_rst_busy", 64'(busy), 64'd0);
        check("after_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        wb_ready = 1'b1;
        tick(10);
        check("no_stale_wb_valid", 64'(wb_valid), 64'd0);

        // Recovery after reset.
        send(6'd0, 1'b1, 5'd9, 64'd4, 64'd5, 64'd0, 64'd20, 1'b0);
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
